// File: rtl/csr_initiator.sv
// csr_initiator: single-outstanding CSR master. Accepts write, read and
// poll-until-match commands, drives the CSR request channel, consumes CSR
// responses for reads and polls, and returns exactly one result per command.
module csr_initiator #(
  parameter int CsrDataWidth = 32,
  parameter int CsrAddrWidth = 32,
  parameter int PollCntWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // Command port
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [1:0]              cmd_op_i,
  input  logic [CsrAddrWidth-1:0] cmd_addr_i,
  input  logic [CsrDataWidth-1:0] cmd_data_i,
  input  logic [CsrDataWidth-1:0] cmd_mask_i,
  input  logic [PollCntWidth-1:0] poll_limit_i,
  // Result port
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [CsrDataWidth-1:0] res_data_o,
  output logic                    res_err_o,
  // CSR request channel
  output logic [CsrDataWidth-1:0] csr_req_data_o,
  output logic [CsrAddrWidth-1:0] csr_req_addr_o,
  output logic                    csr_req_write_o,
  output logic                    csr_req_valid_o,
  input  logic                    csr_req_ready_i,
  // CSR response channel
  input  logic [CsrDataWidth-1:0] csr_rsp_data_i,
  input  logic                    csr_rsp_valid_i,
  output logic                    csr_rsp_ready_o,
  // Status
  output logic                    busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_REQ      = 2'b01,
    ST_WAIT_RSP = 2'b10,
    ST_RESULT   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_POLL    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  state_e                  r_state;
  state_e                  w_state_nxt;

  // Latched command
  op_e                     r_op;
  logic [CsrAddrWidth-1:0] r_addr;
  logic [CsrDataWidth-1:0] r_data;
  logic [CsrDataWidth-1:0] r_mask;
  logic [PollCntWidth-1:0] r_limit;
  logic [PollCntWidth-1:0] r_cnt;

  // Result held for the result port
  logic [CsrDataWidth-1:0] r_res_data;
  logic                    r_res_err;

  logic                    w_cmd_hs;
  logic                    w_req_hs;
  logic                    w_rsp_hs;
  logic                    w_res_hs;
  logic                    w_cmd_illegal;
  logic                    w_poll_match;
  logic                    w_poll_timeout;
  logic [PollCntWidth-1:0] w_cnt_inc;

  // Handshakes use the state-decoded ready/valid outputs, never input-to-output paths.
  assign w_cmd_hs       = cmd_valid_i && cmd_ready_o;
  assign w_req_hs       = csr_req_valid_o && csr_req_ready_i;
  assign w_rsp_hs       = csr_rsp_valid_i && csr_rsp_ready_o;
  assign w_res_hs       = res_valid_o && res_ready_i;
  assign w_cmd_illegal  = (cmd_op_i == OP_ILLEGAL);

  // Masked compare: only bits set in the mask take part; mask 0 always matches.
  assign w_poll_match   = ((csr_rsp_data_i ^ r_data) & r_mask) == '0;
  // Counter wraps silently when the limit is 0 (unlimited polling).
  assign w_cnt_inc      = r_cnt + PollCntWidth'(1);
  assign w_poll_timeout = (r_limit != '0) && (w_cnt_inc == r_limit);

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is assigned with <= so every flop samples
    // pre-edge values; a blocking = here would create order-dependent races.
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_state_nxt     = r_state;
    cmd_ready_o     = 1'b0;
    csr_req_valid_o = 1'b0;
    csr_req_write_o = 1'b0;
    csr_req_addr_o  = '0;
    csr_req_data_o  = '0;
    csr_rsp_ready_o = 1'b0;
    res_valid_o     = 1'b0;
    res_data_o      = '0;
    res_err_o       = 1'b0;
    busy_o          = (r_state != ST_IDLE);

    case (r_state)
      ST_IDLE: begin
        cmd_ready_o = !rst_i;
        if (w_cmd_hs) begin
          w_state_nxt = w_cmd_illegal ? ST_RESULT : ST_REQ;
        end
      end

      ST_REQ: begin
        csr_req_valid_o = 1'b1;
        csr_req_addr_o  = r_addr;
        csr_req_write_o = (r_op == OP_WRITE);
        csr_req_data_o  = (r_op == OP_WRITE) ? r_data : '0;
        if (w_req_hs) begin
          w_state_nxt = (r_op == OP_WRITE) ? ST_RESULT : ST_WAIT_RSP;
        end
      end

      ST_WAIT_RSP: begin
        csr_rsp_ready_o = 1'b1;
        if (w_rsp_hs) begin
          if ((r_op != OP_POLL) || w_poll_match || w_poll_timeout) begin
            w_state_nxt = ST_RESULT;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end
      end

      ST_RESULT: begin
        res_valid_o = 1'b1;
        res_data_o  = r_res_data;
        res_err_o   = r_res_err;
        if (w_res_hs) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command latch, poll counter and result capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op       <= OP_WRITE;
      r_addr     <= '0;
      r_data     <= '0;
      r_mask     <= '0;
      r_limit    <= '0;
      r_cnt      <= '0;
      r_res_data <= '0;
      r_res_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_hs) begin
            r_op       <= op_e'(cmd_op_i);
            r_addr     <= cmd_addr_i;
            r_data     <= cmd_data_i;
            r_mask     <= cmd_mask_i;
            r_limit    <= poll_limit_i;
            r_cnt      <= '0;
            // Illegal ops go straight to RESULT carrying an error and data 0.
            r_res_data <= '0;
            r_res_err  <= w_cmd_illegal;
          end
        end

        ST_REQ: begin
          if (w_req_hs && (r_op == OP_WRITE)) begin
            r_res_data <= '0;
            r_res_err  <= 1'b0;
          end
        end

        ST_WAIT_RSP: begin
          if (w_rsp_hs) begin
            // Every response is captured so a timeout reports the last data seen.
            r_res_data <= csr_rsp_data_i;
            if ((r_op == OP_POLL) && !w_poll_match) begin
              r_cnt     <= w_cnt_inc;
              r_res_err <= w_poll_timeout;
            end else begin
              r_res_err <= 1'b0;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule
